// File: rtl/systolic_load_mac.sv
// Loading sequencer plus a row of signed MAC cells; the sequencer enables one MAC per cycle after start.
// Latency: one cycle from a sampled enable to acc_out/valid_out; no backpressure, and start is ignored while busy.
module systolic_load_mac #(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int N_LOAD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [N_MACS-1:0]       valid_ctrl,
  input  logic [N_MACS-1:0]       valid_in_1,
  input  logic [N_MACS-1:0]       valid_in_2,
  input  logic [N_MACS-1:0]       clear,
  input  logic signed [ACC_W-1:0] a_in,
  input  logic [ACC_W-1:0]        w_0,
  input  logic [ACC_W-1:0]        w_1,
  input  logic [ACC_W-1:0]        w_2,
  input  logic [ACC_W-1:0]        w_3,
  output logic signed [ACC_W-1:0] acc_out_0,
  output logic signed [ACC_W-1:0] acc_out_1,
  output logic signed [ACC_W-1:0] acc_out_2,
  output logic signed [ACC_W-1:0] acc_out_3,
  output logic [N_MACS-1:0]       valid_out
);

  localparam int KW = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state, state_nxt;
  logic [KW-1:0]     k, k_nxt;
  logic              busy_nxt;
  logic [N_MACS-1:0] vctrl_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      k          <= '0;
      busy       <= 1'b0;
      valid_ctrl <= '0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      busy       <= busy_nxt;
      valid_ctrl <= vctrl_nxt;
    end
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    busy_nxt  = 1'b0;
    vctrl_nxt = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          k_nxt     = '0;
        end
      end
      LOAD: begin
        if (k == KW'(N_LOAD - 1)) begin
          state_nxt = IDLE;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
    if (state_nxt == LOAD) begin
      busy_nxt  = 1'b1;
      vctrl_nxt = N_MACS'(1) << k_nxt;
    end
  end

  logic signed [ACC_W-1:0] acc   [N_MACS];
  logic        [ACC_W-1:0] w_arr [N_MACS];

  assign w_arr[0] = w_0;
  assign w_arr[1] = w_1;
  assign w_arr[2] = w_2;
  assign w_arr[3] = w_3;

  logic unused_w_hi;
  assign unused_w_hi = ^{w_0[ACC_W-1:W], w_1[ACC_W-1:W], w_2[ACC_W-1:W], w_3[ACC_W-1:W]};

  for (genvar i = 0; i < N_MACS; i++) begin : g_mac
    logic signed [ACC_W-1:0]   left_op, right_op, op;
    logic signed [W-1:0]       wt;
    logic signed [ACC_W+W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      vo_q;
    logic                      en;

    // Edge cells have no neighbour on one side and fall back to the broadcast input.
    if (i == 0) begin : g_left_edge
      assign left_op = a_in;
    end else begin : g_left
      assign left_op = acc[i-1];
    end
    if (i == N_MACS - 1) begin : g_right_edge
      assign right_op = a_in;
    end else begin : g_right
      assign right_op = acc[i+1];
    end

    always_comb begin
      op = a_in;
      if (valid_ctrl[i])      op = a_in;
      else if (valid_in_1[i]) op = left_op;
      else if (valid_in_2[i]) op = right_op;
    end

    assign en   = valid_ctrl[i] | valid_in_1[i] | valid_in_2[i];
    assign wt   = w_arr[i][W-1:0];
    assign prod = op * wt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_q <= '0;
        vo_q  <= 1'b0;
      end else if (clear[i]) begin
        acc_q <= '0;
        vo_q  <= 1'b0;
      end else if (en) begin
        acc_q <= acc_q + prod[ACC_W-1:0];
        vo_q  <= 1'b1;
      end else begin
        vo_q  <= 1'b0;
      end
    end

    assign acc[i]       = acc_q;
    assign valid_out[i] = vo_q;
  end

  assign acc_out_0 = acc[0];
  assign acc_out_1 = acc[1];
  assign acc_out_2 = acc[2];
  assign acc_out_3 = acc[3];

endmodule

// File: tb/tb_systolic_load_mac.sv
// Directed bench for systolic_load_mac: expected updates are queued by the stimulus and checked by a monitor.
module tb_systolic_load_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               busy;
  logic [3:0]         valid_ctrl;
  logic [3:0]         valid_in_1;
  logic [3:0]         valid_in_2;
  logic [3:0]         clear;
  logic signed [15:0] a_in;
  logic [15:0]        w_0, w_1, w_2, w_3;
  logic signed [15:0] acc_out_0, acc_out_1, acc_out_2, acc_out_3;
  logic [3:0]         valid_out;

  systolic_load_mac #(.W(8), .ACC_W(16), .N_MACS(4), .N_LOAD(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .valid_ctrl(valid_ctrl),
    .valid_in_1(valid_in_1), .valid_in_2(valid_in_2), .clear(clear), .a_in(a_in),
    .w_0(w_0), .w_1(w_1), .w_2(w_2), .w_3(w_3),
    .acc_out_0(acc_out_0), .acc_out_1(acc_out_1), .acc_out_2(acc_out_2), .acc_out_3(acc_out_3),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  vo;
    logic [15:0] a0, a1, a2, a3;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sb_idx = 0;
  int   en_cnt;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t snap();
    return {valid_out, acc_out_0, acc_out_1, acc_out_2, acc_out_3};
  endfunction

  task automatic push(input logic [3:0] vo, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3);
    sb_q.push_back({vo, a0, a1, a2, a3});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic clear_all();
    clear = 4'hF;
    cyc(1);
    clear = 4'h0;
    chk("cleared", snap(), '0);
  endtask

  // Every update strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && valid_out !== 4'b0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_update", snap(), '0);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("update%0d", sb_idx), snap(), mon_e);
        sb_idx++;
      end
    end
  end

  initial begin
    rst        = 1'b0;
    start      = 1'($urandom);
    valid_in_1 = 4'($urandom);
    valid_in_2 = 4'($urandom);
    clear      = 4'($urandom);
    a_in       = 16'($urandom);
    w_0 = 16'($urandom); w_1 = 16'($urandom); w_2 = 16'($urandom); w_3 = 16'($urandom);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_vctrl", valid_ctrl, 0);
    chk("rst_state", snap(), '0);
    cyc(2);
    chk("rst_held", {busy, valid_ctrl, snap()}, '0);

    start = 0; valid_in_1 = 0; valid_in_2 = 0; clear = 0; a_in = 0;
    w_0 = 0; w_1 = 0; w_2 = 0; w_3 = 0;
    rst = 1'b1;
    cyc(3);
    chk("idle_after_rst", {busy, valid_ctrl, snap()}, '0);

    // Basic load
    w_0 = 2; w_1 = 3; w_2 = 4; w_3 = 5; a_in = 10;
    push(4'b0001, 20, 0, 0, 0);
    push(4'b0010, 20, 30, 0, 0);
    pulse_start();
    chk("load0_busy", busy, 1);
    chk("load0_vctrl", valid_ctrl, 4'b0001);
    cyc(1);
    chk("load1_busy", busy, 1);
    chk("load1_vctrl", valid_ctrl, 4'b0010);
    cyc(1);
    chk("done_busy", busy, 0);
    chk("done_vctrl", valid_ctrl, 0);
    cyc(2);

    // Second sequence accumulates on top, then clear both
    push(4'b0001, 40, 30, 0, 0);
    push(4'b0010, 40, 60, 0, 0);
    pulse_start();
    cyc(4);
    clear = 4'b0011;
    cyc(1);
    clear = 4'b0000;
    chk("clear_0011", snap(), '0);

    // Negative weight with junk in the ignored upper weight bits
    w_0 = 16'hABFE; a_in = 10;
    push(4'b0001, 16'hFFEC, 0, 0, 0);
    push(4'b0010, 16'hFFEC, 30, 0, 0);
    pulse_start();
    cyc(4);
    clear_all();

    // Product truncation
    w_0 = 2; a_in = 16'h7FFF;
    push(4'b0001, 16'hFFFE, 0, 0, 0);
    push(4'b0010, 16'hFFFE, 16'h7FFD, 0, 0);
    pulse_start();
    cyc(4);
    clear_all();

    // Left-neighbour chain; MAC 0 falls back to a_in
    a_in = 10; w_0 = 2; w_1 = 3;
    valid_in_1 = 4'b0001;
    push(4'b0001, 20, 0, 0, 0);
    cyc(1);
    a_in = 99; valid_in_1 = 4'b0010;
    push(4'b0010, 20, 60, 0, 0);
    cyc(1);
    clear = 4'b0010;
    cyc(1);
    valid_in_1 = 0; clear = 0;
    chk("clear_beats_enable", snap(), {4'b0, 16'd20, 16'd0, 16'd0, 16'd0});

    // Right-neighbour chain; MAC 3 falls back to a_in; left wins over right
    a_in = 4; w_2 = 4; w_3 = 5;
    valid_in_2 = 4'b1000;
    push(4'b1000, 20, 0, 0, 20);
    cyc(1);
    a_in = 0; valid_in_2 = 4'b0100;
    push(4'b0100, 20, 0, 80, 20);
    cyc(1);
    valid_in_1 = 4'b0100;
    push(4'b0100, 20, 0, 80, 20);
    cyc(1);
    valid_in_1 = 0; valid_in_2 = 0;
    cyc(1);
    clear_all();

    // Start held high while busy gives exactly two enables
    w_0 = 2; w_1 = 3; a_in = 10;
    push(4'b0001, 20, 0, 0, 0);
    push(4'b0010, 20, 30, 0, 0);
    en_cnt = 0;
    start = 1'b1;
    repeat (2) begin
      cyc(1);
      if (valid_ctrl != 0) en_cnt++;
    end
    start = 1'b0;
    repeat (5) begin
      cyc(1);
      if (valid_ctrl != 0) en_cnt++;
    end
    chk("enable_count", en_cnt, 2);
    clear_all();

    // Reset in LOAD(0) aborts the sequence immediately
    pulse_start();
    chk("pre_abort_vctrl", valid_ctrl, 4'b0001);
    rst = 1'b0;
    #1;
    chk("abort_vctrl", valid_ctrl, 0);
    chk("abort_busy", busy, 0);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    chk("after_abort", {busy, valid_ctrl, snap()}, '0);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
